// File: rtl/switch_allocator.sv
// Five-port wormhole switch allocator: each output locks to one input for a whole packet.
// Arbitration is round-robin per output (FAIR=1) or fixed priority LOCAL>WEST>NORTH>EAST>SOUTH.
module switch_allocator #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] buffer_req,
  input  logic [2:0] buffer_dport [0:4],
  input  logic [4:0] buffer_tail,
  input  logic [4:0] out_ready,
  output logic [4:0] buffer_grant,
  output logic [2:0] xbar_sel [0:4],
  output logic [4:0] out_valid,
  output logic [4:0] out_lock
);

  localparam int unsigned NP = 5;
  localparam int unsigned PW = 3;
  localparam logic [PW-1:0] NONE = 3'b111;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q [NP];
  logic [PW-1:0]   owner_q [NP];
  logic [PW-1:0]   ptr_q   [NP];

  logic [NP-1:0]   busy;
  logic [NP-1:0]   cand [NP];
  logic [NP-1:0]   found;
  logic [PW-1:0]   pick [NP];
  logic [NP-1:0]   grant;
  logic [NP-1:0]   valid;
  logic [NP-1:0]   release_o;

  // (a + k) mod NP for a < NP and k < NP
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int unsigned k);
    logic [3:0] s;
    s = 4'(a) + 4'(k);
    if (s >= 4'(NP)) s = s - 4'(NP);
    return PW'(s);
  endfunction

  // Inputs that currently own some locked output
  always_comb begin
    busy = '0;
    for (int o = 0; o < NP; o++) begin
      if (state_q[o] == LOCKED) begin
        for (int i = 0; i < NP; i++) begin
          if (owner_q[o] == PW'(i)) busy[i] = 1'b1;
        end
      end
    end
  end

  // Candidate sets; invalid dport codes never match an output index
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NP; i++) begin
        cand[o][i] = buffer_req[i] && (buffer_dport[i] == PW'(o)) && !busy[i];
      end
    end
  end

  // Per-output arbitration
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      found[o] = 1'b0;
      pick[o]  = NONE;
      if (FAIR) begin
        for (int k = 0; k < NP; k++) begin
          if (!found[o] && cand[o][wrap_add(ptr_q[o], k)]) begin
            found[o] = 1'b1;
            pick[o]  = wrap_add(ptr_q[o], k);
          end
        end
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (!found[o] && cand[o][i]) begin
            found[o] = 1'b1;
            pick[o]  = PW'(i);
          end
        end
      end
    end
  end

  // Flit transfer on locked outputs; suppressed while reset is asserted
  always_comb begin
    grant     = '0;
    valid     = '0;
    release_o = '0;
    for (int o = 0; o < NP; o++) begin
      if (rst && state_q[o] == LOCKED) begin
        for (int i = 0; i < NP; i++) begin
          if (owner_q[o] == PW'(i) && buffer_req[i] && out_ready[o]) begin
            grant[i]     = 1'b1;
            valid[o]     = 1'b1;
            release_o[o] = buffer_tail[i];
          end
        end
      end
    end
  end

  // Per-output state machine; release cycle never reallocates
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= NONE;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NP; o++) begin
        case (state_q[o])
          IDLE: begin
            if (found[o]) begin
              state_q[o] <= LOCKED;
              owner_q[o] <= pick[o];
            end
          end
          LOCKED: begin
            if (release_o[o]) begin
              state_q[o] <= IDLE;
              owner_q[o] <= NONE;
              if (FAIR) ptr_q[o] <= wrap_add(owner_q[o], 1);
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    buffer_grant = grant;
    out_valid    = valid;
    for (int o = 0; o < NP; o++) begin
      xbar_sel[o] = owner_q[o];
      out_lock[o] = (state_q[o] == LOCKED);
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: a driver queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the round-robin or fixed-priority instance.
module tb_switch_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] buffer_req;
  logic [2:0] buffer_dport [0:4];
  logic [4:0] buffer_tail;
  logic [4:0] out_ready;

  logic [4:0] grant_a, valid_a, lock_a;
  logic [2:0] xs_a [0:4];
  logic [4:0] grant_b, valid_b, lock_b;
  logic [2:0] xs_b [0:4];

  always #5 clk = ~clk;

  switch_allocator #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst), .buffer_req(buffer_req), .buffer_dport(buffer_dport),
    .buffer_tail(buffer_tail), .out_ready(out_ready), .buffer_grant(grant_a),
    .xbar_sel(xs_a), .out_valid(valid_a), .out_lock(lock_a)
  );

  switch_allocator #(.FAIR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .buffer_req(buffer_req), .buffer_dport(buffer_dport),
    .buffer_tail(buffer_tail), .out_ready(out_ready), .buffer_grant(grant_b),
    .xbar_sel(xs_b), .out_valid(valid_b), .out_lock(lock_b)
  );

  typedef struct packed {
    logic        fp;
    logic [4:0]  grant;
    logic [4:0]  valid;
    logic [4:0]  lock;
    logic [14:0] xs;
    logic [15:0] tag;
  } exp_t;

  localparam logic [14:0] X = 15'h7FFF;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   seq   = 0;

  function automatic logic [14:0] xs1(input int o, input logic [2:0] v);
    logic [14:0] r;
    r = X;
    r[3*o +: 3] = v;
    return r;
  endfunction

  function automatic logic [14:0] dpm(input logic [4:0] mask, input logic [2:0] v);
    logic [14:0] r;
    r = X;
    for (int i = 0; i < 5; i++) if (mask[i]) r[3*i +: 3] = v;
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [14:0] act, input logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [4:0] req, input logic [14:0] dp,
                       input logic [4:0] tail, input logic [4:0] rdy, input logic fp,
                       input logic [4:0] g, input logic [4:0] v, input logic [4:0] l,
                       input logic [14:0] xs);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    buffer_req  = req;
    for (int i = 0; i < 5; i++) buffer_dport[i] = dp[3*i +: 3];
    buffer_tail = tail;
    out_ready   = rdy;
    e.fp = fp; e.grant = g; e.valid = v; e.lock = l; e.xs = xs; e.tag = 16'(seq);
    q.push_back(e);
    seq++;
  endtask

  // Monitor: compare the selected instance's outputs mid-cycle
  exp_t        cur;
  logic [14:0] xs_act;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      for (int o = 0; o < 5; o++) xs_act[3*o +: 3] = cur.fp ? xs_b[o] : xs_a[o];
      chk("grant",    int'(cur.tag), 15'(cur.fp ? grant_b : grant_a), 15'(cur.grant));
      chk("out_valid", int'(cur.tag), 15'(cur.fp ? valid_b : valid_a), 15'(cur.valid));
      chk("out_lock", int'(cur.tag), 15'(cur.fp ? lock_b : lock_a),   15'(cur.lock));
      chk("xbar_sel", int'(cur.tag), xs_act, cur.xs);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; buffer_req = '0; buffer_tail = '0; out_ready = '0;
    for (int i = 0; i < 5; i++) buffer_dport[i] = 3'd7;

    // reset holds everything idle even with requests present
    apply(0, 5'h1F, dpm(5'h1F, 3'd0), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(0, 5'h1F, dpm(5'h1F, 3'd0), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);

    // single-flit packet LOCAL -> EAST
    apply(1, 5'h01, dpm(5'h01, 3'd3), 5'h01, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h01, dpm(5'h01, 3'd3), 5'h01, 5'h1F, 0, 5'h01, 5'h08, 5'h08, xs1(3, 3'd0));
    apply(1, 5'h00, X,                5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);

    // round-robin contention on output 0: inputs 1,2,4 with 3-flit packets
    apply(1, 5'h16, dpm(5'h16, 3'd0), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h16, dpm(5'h16, 3'd0), 5'h00, 5'h1F, 0, 5'h02, 5'h01, 5'h01, xs1(0, 3'd1));
    apply(1, 5'h16, dpm(5'h16, 3'd0), 5'h00, 5'h1F, 0, 5'h02, 5'h01, 5'h01, xs1(0, 3'd1));
    apply(1, 5'h16, dpm(5'h16, 3'd0), 5'h02, 5'h1F, 0, 5'h02, 5'h01, 5'h01, xs1(0, 3'd1));
    apply(1, 5'h14, dpm(5'h14, 3'd0), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h14, dpm(5'h14, 3'd0), 5'h00, 5'h1F, 0, 5'h04, 5'h01, 5'h01, xs1(0, 3'd2));
    apply(1, 5'h14, dpm(5'h14, 3'd0), 5'h00, 5'h1F, 0, 5'h04, 5'h01, 5'h01, xs1(0, 3'd2));
    apply(1, 5'h14, dpm(5'h14, 3'd0), 5'h04, 5'h1F, 0, 5'h04, 5'h01, 5'h01, xs1(0, 3'd2));
    apply(1, 5'h10, dpm(5'h10, 3'd0), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h10, dpm(5'h10, 3'd0), 5'h00, 5'h1F, 0, 5'h10, 5'h01, 5'h01, xs1(0, 3'd4));
    apply(1, 5'h10, dpm(5'h10, 3'd0), 5'h00, 5'h1F, 0, 5'h10, 5'h01, 5'h01, xs1(0, 3'd4));
    apply(1, 5'h10, dpm(5'h10, 3'd0), 5'h10, 5'h1F, 0, 5'h10, 5'h01, 5'h01, xs1(0, 3'd4));
    apply(1, 5'h16, dpm(5'h16, 3'd0), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h16, dpm(5'h16, 3'd0), 5'h02, 5'h1F, 0, 5'h02, 5'h01, 5'h01, xs1(0, 3'd1));
    apply(1, 5'h00, X,                5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);

    // back-pressure on output 1; owner's dport changes mid-packet and is ignored
    apply(1, 5'h08, dpm(5'h08, 3'd1), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h08, dpm(5'h08, 3'd1), 5'h00, 5'h1F, 0, 5'h08, 5'h02, 5'h02, xs1(1, 3'd3));
    apply(1, 5'h08, dpm(5'h08, 3'd0), 5'h00, 5'h1D, 0, 5'h00, 5'h00, 5'h02, xs1(1, 3'd3));
    apply(1, 5'h08, dpm(5'h08, 3'd0), 5'h00, 5'h1D, 0, 5'h00, 5'h00, 5'h02, xs1(1, 3'd3));
    apply(1, 5'h08, dpm(5'h08, 3'd0), 5'h00, 5'h1D, 0, 5'h00, 5'h00, 5'h02, xs1(1, 3'd3));
    apply(1, 5'h08, dpm(5'h08, 3'd0), 5'h08, 5'h1F, 0, 5'h08, 5'h02, 5'h02, xs1(1, 3'd3));
    apply(1, 5'h00, X,                5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);

    // parallel: 0->2, 3->4 together; input 1 targets invalid port 6
    apply(1, 5'h0B, 15'b111_100_111_110_010, 5'h0B, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h0B, 15'b111_100_111_110_010, 5'h0B, 5'h1F, 0, 5'h09, 5'h14, 5'h14,
          15'b011_111_000_111_111);
    apply(1, 5'h02, dpm(5'h02, 3'd6), 5'h02, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);

    // reset mid-packet on output 2, then reallocation
    apply(1, 5'h04, dpm(5'h04, 3'd2), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h04, dpm(5'h04, 3'd2), 5'h00, 5'h1F, 0, 5'h04, 5'h04, 5'h04, xs1(2, 3'd2));
    apply(0, 5'h04, dpm(5'h04, 3'd2), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h04, xs1(2, 3'd2));
    apply(1, 5'h04, dpm(5'h04, 3'd2), 5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h04, dpm(5'h04, 3'd2), 5'h04, 5'h1F, 0, 5'h04, 5'h04, 5'h04, xs1(2, 3'd2));
    apply(1, 5'h00, X,                5'h00, 5'h1F, 0, 5'h00, 5'h00, 5'h00, X);

    // fixed priority: inputs 2 and 4 to output 1, input 2 keeps winning
    apply(1, 5'h14, dpm(5'h14, 3'd1), 5'h14, 5'h1F, 1, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h14, dpm(5'h14, 3'd1), 5'h14, 5'h1F, 1, 5'h04, 5'h02, 5'h02, xs1(1, 3'd2));
    apply(1, 5'h14, dpm(5'h14, 3'd1), 5'h14, 5'h1F, 1, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h14, dpm(5'h14, 3'd1), 5'h14, 5'h1F, 1, 5'h04, 5'h02, 5'h02, xs1(1, 3'd2));
    apply(1, 5'h14, dpm(5'h14, 3'd1), 5'h14, 5'h1F, 1, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h14, dpm(5'h14, 3'd1), 5'h14, 5'h1F, 1, 5'h04, 5'h02, 5'h02, xs1(1, 3'd2));
    apply(1, 5'h10, dpm(5'h10, 3'd1), 5'h10, 5'h1F, 1, 5'h00, 5'h00, 5'h00, X);
    apply(1, 5'h10, dpm(5'h10, 3'd1), 5'h10, 5'h1F, 1, 5'h10, 5'h02, 5'h02, xs1(1, 3'd4));
    apply(1, 5'h00, X,                5'h00, 5'h1F, 1, 5'h00, 5'h00, 5'h00, X);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
